// File: rtl/cache_fill_arbiter_if.sv
// Handshake bundle between CPU / miss logic / RAM and the data-array write sequencer.
interface cache_fill_arbiter_if #(
    parameter int AddrWidth    = 8,
    parameter int BeatsPerLine = 4
);
    localparam int BeatBits = $clog2(BeatsPerLine);

    logic                          cpu_wr_valid;
    logic [AddrWidth-1:0]          cpu_wr_addr;
    logic                          cpu_wr_ready;
    logic                          refill_start;
    logic [AddrWidth-BeatBits-1:0] refill_line;
    logic                          ram_beat_valid;
    logic                          ram_beat_ready;
    logic                          refill_busy;
    logic                          refill_done;
    logic                          seleccion;
    logic                          arr_wr_en;
    logic [AddrWidth-1:0]          arr_wr_addr;

    modport master (
        output cpu_wr_valid, cpu_wr_addr, refill_start, refill_line, ram_beat_valid,
        input  cpu_wr_ready, ram_beat_ready, refill_busy, refill_done,
               seleccion, arr_wr_en, arr_wr_addr
    );

    modport slave (
        input  cpu_wr_valid, cpu_wr_addr, refill_start, refill_line, ram_beat_valid,
        output cpu_wr_ready, ram_beat_ready, refill_busy, refill_done,
               seleccion, arr_wr_en, arr_wr_addr
    );
endinterface

// File: rtl/cache_fill_arbiter.sv
// Write-port sequencer for the cache data array: single-beat CPU writes vs multi-beat line refills.
module cache_fill_arbiter #(
    parameter int SizeDataMux  = 64,
    parameter int AddrWidth    = 8,
    parameter int BeatsPerLine = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    cache_fill_arbiter_if.slave bus
);
    localparam int BeatBits = $clog2(BeatsPerLine);
    localparam logic [BeatBits-1:0] LastBeat = BeatBits'(BeatsPerLine - 1);

    typedef enum logic [1:0] {IDLE, REFILL, DONE} state_t;

    state_t                        state;
    logic [AddrWidth-BeatBits-1:0] line_q;
    logic [BeatBits-1:0]           beat_cnt;
    logic                          ready_en;
    logic                          in_refill;
    logic                          beat_hs;
    logic                          cpu_hs;

    assign in_refill = (state == REFILL);
    assign beat_hs   = bus.ram_beat_valid & in_refill;
    // ready_en keeps the CPU port closed for the first cycle after reset release.
    assign cpu_hs    = bus.cpu_wr_valid & ready_en & ~in_refill;

    assign bus.cpu_wr_ready   = ready_en & ~in_refill;
    assign bus.ram_beat_ready = in_refill;
    assign bus.seleccion      = ~in_refill;
    assign bus.refill_busy    = in_refill;
    assign bus.refill_done    = (state == DONE);
    assign bus.arr_wr_en      = cpu_hs | beat_hs;
    assign bus.arr_wr_addr    = in_refill ? {line_q, beat_cnt} : bus.cpu_wr_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            line_q   <= '0;
            beat_cnt <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            case (state)
                IDLE, DONE: begin
                    if (bus.refill_start) begin
                        line_q   <= bus.refill_line;
                        beat_cnt <= '0;
                        state    <= REFILL;
                    end else begin
                        state    <= IDLE;
                    end
                end
                REFILL: begin
                    // refill_start is deliberately ignored here; the miss logic waits for refill_done.
                    if (beat_hs) begin
                        if (beat_cnt == LastBeat) begin
                            beat_cnt <= '0;
                            state    <= DONE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/cache_fill_arbiter.md
# cache_fill_arbiter

Sequencing controller for the 64-bit cache data-array write port. It arbitrates between single-beat CPU write hits and multi-beat RAM line refills, and drives the `seleccion` input of the 64-bit CPU/RAM data mux (1 = CPU data, 0 = RAM data). It also drives the array write enable and word address, and reports refill progress to the cache miss logic.

## Interface
- `SizeDataMux`, 64: data width; passed through to the mux, no internal data storage.
- `AddrWidth`, 8: data-array word-address width.
- `BeatsPerLine`, 4: words per cache line; power of two, ≥2. `BeatBits = log2(BeatsPerLine)`.
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cpu_wr_valid`  in  1  CPU write-hit request; holds `cpu_wr_addr` and its data stable until accepted.
- `cpu_wr_addr`  in  AddrWidth  CPU target word address.
- `cpu_wr_ready`  out  1  CPU write accepted this cycle when high with `cpu_wr_valid`.
- `refill_start`  in  1  one-cycle pulse requesting a line refill.
- `refill_line`  in  AddrWidth-BeatBits  line index to refill; sampled with `refill_start`.
- `ram_beat_valid`  in  1  RAM data word present on the mux RAM input.
- `ram_beat_ready`  out  1  beat consumed this cycle when high with `ram_beat_valid`.
- `refill_busy`  out  1  refill in progress.
- `refill_done`  out  1  one-cycle pulse after the last beat is written.
- `seleccion`  out  1  mux select: 1 = CPU, 0 = RAM.
- `arr_wr_en`  out  1  data-array write enable.
- `arr_wr_addr`  out  AddrWidth  data-array word address.

## Operation
- States:
  - IDLE: refill not active.
  - REFILL: beats are being accepted.
  - DONE: one cycle; `refill_done`=1.
- Registers: state, `line_q` (AddrWidth-BeatBits), `beat_cnt` (BeatBits), `ready_en` (reset 0, set on the first edge after `rst_n` rises).
- `cpu_wr_ready` = `ready_en` & (state ≠ REFILL). `ram_beat_ready` = (state == REFILL).
- `seleccion` = (state ≠ REFILL). `arr_wr_en` = (`cpu_wr_valid` & `cpu_wr_ready`) | (`ram_beat_valid` & `ram_beat_ready`).
- `arr_wr_addr`:
  - state ≠ REFILL: `cpu_wr_addr`.
  - REFILL: {`line_q`, `beat_cnt`}.
- `refill_busy` = (state == REFILL). `refill_done` = (state == DONE).
- IDLE/DONE + `refill_start`:
  - `line_q` ← `refill_line`, `beat_cnt` ← 0, → REFILL.
  - Without `refill_start`: DONE → IDLE, IDLE stays.
- REFILL + beat handshake:
  - `beat_cnt` increments.
  - On beat index BeatsPerLine-1: `beat_cnt` wraps to 0 and state → DONE.
  - No handshake: state and counter hold.
- `refill_start` during REFILL is ignored; miss logic must wait for `refill_done`.
- `refill_start` and a CPU write in the same IDLE/DONE cycle: the CPU write completes that cycle with `seleccion`=1, and REFILL begins next cycle.
- CPU writes stall for the entire REFILL. No CPU/RAM address-conflict check is needed because CPU writes never overlap a refill.
- `rst_n` low at any time, including mid-refill: state → IDLE, `beat_cnt` → 0, `line_q` → 0, `ready_en` → 0 immediately. The partial line is abandoned, and miss logic reissues the refill.

## Timing
- Reset values: `cpu_wr_ready`=0, `ram_beat_ready`=0, `refill_busy`=0, `refill_done`=0, `seleccion`=1, `arr_wr_en`=0, `arr_wr_addr`=`cpu_wr_addr` (don't-care while `arr_wr_en`=0).
- `cpu_wr_ready` rises on the first rising edge after reset release.
- CPU write: zero-cycle accept. The array writes on the same edge as the handshake. Throughput is 1 write/cycle in IDLE/DONE.
- Refill timing:
  - `refill_start` at cycle T gives `ram_beat_ready`=1 from T+1.
  - With `ram_beat_valid` held high, beats are written T+1..T+BeatsPerLine.
  - `refill_done` fires at T+BeatsPerLine+1, and a CPU write is accepted in that same cycle.
- RAM stalls (`ram_beat_valid`=0) extend REFILL cycle-for-cycle with no write.
- All outputs are combinational from registered state plus request inputs. There is no input-to-output path from `refill_start`.

## Test plan
- Reset release, `cpu_wr_valid`=1 with addr 0x12: no write in the first cycle after release; then `arr_wr_en`=1, `arr_wr_addr`=0x12, `seleccion`=1, ready=1.
- `refill_start` with line 0x05, `ram_beat_valid` held 1: writes to 0x14, 0x15, 0x16, 0x17 on 4 consecutive cycles with `seleccion`=0; `refill_done` pulses once the next cycle; `refill_busy` is high for exactly 4 cycles.
- Refill of line 0x3F with `ram_beat_valid` toggling 1,0,1,0,…: addresses 0xFC..0xFF written only on valid cycles; `cpu_wr_valid` held 1 throughout sees `cpu_wr_ready`=0 until the DONE cycle, then writes.
- Same-cycle `refill_start`(line 0x02) and CPU write to 0x40 in IDLE: 0x40 written that cycle with `seleccion`=1; beats 0x08..0x0B follow from the next cycle.
- `refill_start` pulsed again during REFILL at beat 2: ignored; the original line completes with exactly 4 writes and one `refill_done`.
- `rst_n` asserted after beat 1 of a refill: `arr_wr_en`, `refill_busy`, and `ram_beat_ready` drop to 0 immediately. After release, a new refill of line 0x01 writes 0x04..0x07 starting from beat 0.
